ft245_tx: RTL and testbench
===========================

# ft245_tx

Transmit half of the FT232H synchronous-FIFO (FT245-style) interface: moves bytes from the controller toward the host. It buffers controller bytes in a small FIFO, requests the shared `ft_bus` from the bus arbiter, and drives `ft_wr_n` and the data outputs while respecting `ft_txe_n`. It issues `ft_siwu_n` pulses so short replies (ADC register reads, MCP3008 samples) reach the host without waiting for the FT232H buffer to fill. It runs entirely in the `ft_clkout` (60 MHz) domain and sits beside the receive path in `top`.

## Interface
- `DEPTH`, default 16: FIFO depth in bytes, a power of two; `AW = log2(DEPTH)`.
- `SIWU_IDLE`, default 255: number of idle cycles after the last accepted byte before an automatic send-immediate.

- `clk` in 1: `ft_clkout`, 60 MHz.
- `rst` in 1: synchronous, active-high reset. One clock; no other clock domain.
- `tx_data` in 8: byte from the controller.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: FIFO not full. A byte is taken on a cycle where `tx_valid && tx_ready`.
- `flush` in 1: single-cycle request for send-immediate.
- `bus_req` out 1: requests ownership of `ft_bus`.
- `bus_gnt` in 1: the arbiter grants the bus. It stays high until `bus_req` falls.
- `ft_txe_n` in 1: low means the FT232H can accept data.
- `ft_wr_n` out 1: active-low write strobe.
- `ft_siwu_n` out 1: active-low send-immediate.
- `ft_dout` out 8: data to the bus pad.
- `ft_doe` out 1: pad output enable.
- `fifo_count` out AW+1: current FIFO occupancy.
- `busy` out 1: high when the state is not IDLE or `fifo_count != 0`.

## Operation
- **FIFO:** circular buffer with `DEPTH` entries and AW+1-bit read/write pointers.
  - Full when the MSBs of the two pointers differ and the low bits are equal.
  - A push and a pop in the same cycle are both legal.
  - When full, `tx_ready` is 0 and a write is ignored.
- **States:** IDLE, REQ, TURN, WRITE, RELEASE.
  - IDLE: if `fifo_count != 0` and `ft_txe_n == 0`, set `bus_req = 1` and go to REQ.
  - REQ: wait for `bus_gnt`. On grant, set `ft_doe = 1` and go to TURN.
  - TURN: one turnaround cycle with `ft_doe = 1` and `ft_wr_n = 1`. Then go to WRITE.
  - WRITE:
    - `ft_dout` equals the FIFO head and `ft_wr_n = 0`.
    - On each rising edge where `ft_wr_n == 0 && ft_txe_n == 0`, the byte is accepted and the read pointer advances.
    - Leave WRITE, setting `ft_wr_n = 1`, when the FIFO will be empty after this pop, or when `ft_txe_n` is high.
    - If `ft_txe_n` rises, the head is not popped and is retried later. A byte is never lost or duplicated.
  - RELEASE: `ft_doe = 0`, `bus_req = 0`, then go to IDLE.
- **Send-immediate:**
  - A pending flag is set by `flush`, or by the idle counter reaching `SIWU_IDLE` after at least one byte has been accepted since the last pulse.
  - The idle counter clears on each accepted byte.
  - When the flag is set, the state is IDLE and `fifo_count == 0`, drive `ft_siwu_n` low for exactly one cycle, then clear the flag.
  - A `flush` that arrives while a pulse is already pending is merged into it.
- **Arithmetic:** pointers wrap modulo 2·DEPTH. `fifo_count = wr_ptr - rd_ptr`, taken as AW+1 bits. The idle counter saturates at `SIWU_IDLE`.

## Timing
- **Reset values:**
  - `ft_wr_n = 1`, `ft_siwu_n = 1`, `ft_doe = 0`, `ft_dout = 0`.
  - `bus_req = 0`, `tx_ready = 1`, `fifo_count = 0`, `busy = 0`.
  - State is IDLE, and the pending flag and counters are 0.
- **Reset mid-transfer:** all of the above take effect on the next edge, and FIFO contents are discarded.
- **Pad and strobe outputs:** all registered. `ft_txe_n` is used combinationally only for the accept decision and for the next-state and `ft_wr_n` logic.
- **Latency:** with `ft_txe_n` low and `bus_gnt` tied high, the first `ft_wr_n` low edge comes 3 cycles after the push edge: IDLE, then REQ, then TURN, then WRITE.
- **Throughput:** one byte per cycle in WRITE.
- **Bus turnaround:** `ft_doe` rises at least one cycle before `ft_wr_n` falls, and falls at least one cycle after `ft_wr_n` rises.
- **Grant loss:** `bus_gnt` is not removed while `bus_req` is high. If it is, the behaviour is undefined and an assertion in the bench flags it.

## Structure
- Shared header `ft245.vh`, holding:
  - the state encodings;
  - the FT232H polarity constants;
  - the turnaround length.
  The receive path also includes this header.
- One sub-module, `sync_fifo`, parameterised by WIDTH and DEPTH. It exposes push/pop/full/empty/count, provides first-word-fall-through data, and is reused by the receive path.

## Test plan
- **Single-byte burst:** reset, push 0xA5 with `ft_txe_n = 0` and grant tied high.
  - `ft_wr_n` is low for exactly one cycle with `ft_dout = 0xA5`.
  - `ft_doe` brackets it by ±1 cycle.
  - `ft_siwu_n` pulses low once, `SIWU_IDLE` cycles later.
- **Back pressure:** push 0x00–0x0F (16 bytes) back-to-back, and hold `ft_txe_n` high for 20 cycles in the middle of the burst.
  - `tx_ready` drops at 16 queued bytes.
  - The host model receives 0x00–0x0F in order with no duplicates.
- **Late grant:** delay `bus_gnt` by 10 cycles.
  - `ft_doe` and `ft_wr_n` stay inactive until the grant.
  - The first write occurs 2 cycles after the grant.
- **Flush during a burst:** pulse `flush` while 5 bytes are queued.
  - `ft_siwu_n` goes low exactly once, in the cycle after the FIFO drains and the state returns to IDLE.
- **Reset mid-burst:** assert `rst` during WRITE.
  - Next edge: `ft_wr_n = 1`, `ft_doe = 0`, `bus_req = 0`, `fifo_count = 0`.
  - No further writes occur.

Source files
------------

// File: rtl/ft245_tx_pkg.sv
// Shared definitions for the FT232H synchronous-FIFO paths: state encodings,
// pad polarities and bus turnaround length. The receive path imports this too.
package ft245_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_TURN    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RELEASE = 3'd4
  } tx_state_t;

  localparam logic TXE_N_READY   = 1'b0;
  localparam logic WR_N_ACTIVE   = 1'b0;
  localparam logic WR_N_IDLE     = 1'b1;
  localparam logic SIWU_N_ACTIVE = 1'b0;
  localparam logic SIWU_N_IDLE   = 1'b1;

  // Cycles with the pad driven but no strobe, before the first write.
  localparam int TURN_CYCLES = 1;

endpackage

// File: rtl/ft245_tx_if.sv
// Controller byte stream, arbiter handshake and FT232H pads of the transmit path.
// master = the ft245_tx block, slave = its surroundings (controller, arbiter, pads).
interface ft245_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       flush;
  logic       bus_req;
  logic       bus_gnt;
  logic       ft_txe_n;
  logic       ft_wr_n;
  logic       ft_siwu_n;
  logic [7:0] ft_dout;
  logic       ft_doe;

  modport master (
    input  tx_data, tx_valid, flush, bus_gnt, ft_txe_n,
    output tx_ready, bus_req, ft_wr_n, ft_siwu_n, ft_dout, ft_doe
  );

  modport slave (
    output tx_data, tx_valid, flush, bus_gnt, ft_txe_n,
    input  tx_ready, bus_req, ft_wr_n, ft_siwu_n, ft_dout, ft_doe
  );

endinterface

// File: rtl/ft245_tx_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers; also exposes
// the entry behind the head so a registered reader can stream one word per cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [WIDTH-1:0]       dout_next,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW-1:0]    rd_next;
  logic             do_push;
  logic             do_pop;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign count     = wr_ptr - rd_ptr;
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign rd_next   = rd_ptr[AW-1:0] + AW'(1);
  assign dout      = mem[rd_ptr[AW-1:0]];
  assign dout_next = mem[rd_next];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ft245_tx.sv
// FT245-style transmit path: buffers controller bytes, borrows the shared pad bus
// from the arbiter, strobes bytes out while the FT232H has room, and issues SIWU.
//
// state    | meaning
// IDLE     | bus released; wait for queued data and txe_n low
// REQ      | bus_req high, waiting for bus_gnt
// TURN     | pad driven, strobe still idle (turnaround)
// WRITE    | wr_n low, one byte per cycle while txe_n low
// RELEASE  | wr_n back high; drop pad enable and bus_req
module ft245_tx
  import ft245_tx_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int SIWU_IDLE = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  ft245_tx_if.master             bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SIWU_IDLE + 1);
  localparam logic [CW-1:0] IDLE_MAX  = CW'(SIWU_IDLE);
  localparam logic [CW-1:0] IDLE_LAST = CW'(SIWU_IDLE - 1);

  tx_state_t     state;
  logic [1:0]    turn_cnt;
  logic [CW-1:0] idle_cnt;
  logic          pending;
  logic          armed;

  logic          full;
  logic          empty;
  logic [7:0]    head;
  logic [7:0]    head_next;
  logic          push;
  logic          accept;
  logic          last;
  logic          fire;
  logic          timer_hit;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.tx_valid),
    .din       (bus.tx_data),
    .pop       (accept),
    .dout      (head),
    .dout_next (head_next),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign bus.tx_ready = !full;
  assign push         = bus.tx_valid && !full;
  assign accept       = (state == ST_WRITE) && (bus.ft_wr_n == WR_N_ACTIVE)
                        && (bus.ft_txe_n == TXE_N_READY);
  // A push landing with the final pop is left for the next bus tenure.
  assign last         = accept && (fifo_count == (AW+1)'(1));
  assign busy         = (state != ST_IDLE) || !empty;
  assign fire         = pending && (state == ST_IDLE) && empty;
  assign timer_hit    = armed && !push && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      turn_cnt    <= '0;
      bus.bus_req <= 1'b0;
      bus.ft_doe  <= 1'b0;
      bus.ft_wr_n <= WR_N_IDLE;
      bus.ft_dout <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty && (bus.ft_txe_n == TXE_N_READY)) begin
            bus.bus_req <= 1'b1;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.bus_gnt) begin
            bus.ft_doe <= 1'b1;
            turn_cnt   <= 2'(TURN_CYCLES - 1);
            state      <= ST_TURN;
          end
        end
        ST_TURN: begin
          if (turn_cnt == 2'd0) begin
            bus.ft_wr_n <= WR_N_ACTIVE;
            bus.ft_dout <= head;
            state       <= ST_WRITE;
          end else begin
            turn_cnt <= turn_cnt - 2'd1;
          end
        end
        ST_WRITE: begin
          if ((bus.ft_txe_n != TXE_N_READY) || last) begin
            bus.ft_wr_n <= WR_N_IDLE;
            state       <= ST_RELEASE;
          end else if (accept) begin
            bus.ft_dout <= head_next;
          end
        end
        ST_RELEASE: begin
          bus.ft_doe  <= 1'b0;
          bus.bus_req <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Send-immediate: a flush merges with an already pending pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending       <= 1'b0;
      armed         <= 1'b0;
      idle_cnt      <= '0;
      bus.ft_siwu_n <= SIWU_N_IDLE;
    end else begin
      bus.ft_siwu_n <= fire ? SIWU_N_ACTIVE : SIWU_N_IDLE;

      if (push)                     idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + CW'(1);

      if (fire)                         pending <= 1'b0;
      else if (bus.flush || timer_hit)  pending <= 1'b1;

      if (push)                   armed <= 1'b1;
      else if (timer_hit || fire) armed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ft245_tx.sv
// Directed bench for ft245_tx: cycle table for a single-byte burst plus
// sequences for back pressure, late grant, flush and reset mid-burst.
module tb_ft245_tx;

  localparam int DEPTH     = 16;
  localparam int SIWU_IDLE = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] fifo_count;
  logic       busy;

  ft245_tx_if bus_if ();

  ft245_tx #(.DEPTH(DEPTH), .SIWU_IDLE(SIWU_IDLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] rx_q[$];
  int  siwu_lows    = 0;
  int  siwu_cyc     = -1;
  int  doe_fall_cyc = -1;
  int  write_cyc    = -1;
  logic doe_q       = 1'b0;
  bit  gnt_seen     = 1'b0;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       txe_n;
    logic       gnt;
    logic [17:0] exp;  // {bus_req, doe, wr_n, siwu_n, tx_ready, dout, fifo_count}
  } vec_t;

  vec_t vecs[7];

  always @(posedge clk) cyc++;

  // Host model and observers, sampled mid-cycle.
  always @(negedge clk) begin
    if (!bus_if.ft_wr_n && !bus_if.ft_txe_n) begin
      rx_q.push_back(bus_if.ft_dout);
      write_cyc = cyc + 1;
    end
    if (!bus_if.ft_siwu_n) begin
      if (siwu_lows == 0) siwu_cyc = cyc;
      siwu_lows++;
    end
    if (doe_q && !bus_if.ft_doe) doe_fall_cyc = cyc;
    doe_q = bus_if.ft_doe;
    if (gnt_seen && bus_if.bus_req)
      assert (bus_if.bus_gnt)
      else begin
        errors++;
        $display("FAIL grant_held: bus_gnt=%0b while bus_req=1, required 1", bus_if.bus_gnt);
      end
    gnt_seen = bus_if.bus_req && (gnt_seen || bus_if.bus_gnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    rx_q.delete();
    siwu_lows    = 0;
    siwu_cyc     = -1;
    doe_fall_cyc = -1;
    write_cyc    = -1;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus_if.tx_valid = 1'b0;
    bus_if.flush    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus_if.tx_valid = 1'b1;
    bus_if.tx_data  = d;
    tick();
    bus_if.tx_valid = 1'b0;
  endtask

  function automatic logic [17:0] pack_out();
    return {bus_if.bus_req, bus_if.ft_doe, bus_if.ft_wr_n, bus_if.ft_siwu_n,
            bus_if.tx_ready, bus_if.ft_dout, fifo_count};
  endfunction

  initial begin
    int e0, g, n_before;

    //              valid data   txe  gnt  req doe wr siwu rdy dout  count
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, {1'b0,1'b0,1'b1,1'b1,1'b1,8'h00,5'd1}};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, {1'b1,1'b0,1'b1,1'b1,1'b1,8'h00,5'd1}};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, {1'b1,1'b1,1'b1,1'b1,1'b1,8'h00,5'd1}};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, {1'b1,1'b1,1'b0,1'b1,1'b1,8'hA5,5'd1}};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, {1'b1,1'b1,1'b1,1'b1,1'b1,8'hA5,5'd0}};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, {1'b0,1'b0,1'b1,1'b1,1'b1,8'hA5,5'd0}};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, {1'b0,1'b0,1'b1,1'b1,1'b1,8'hA5,5'd0}};

    bus_if.tx_data  = 8'h00;
    bus_if.tx_valid = 1'b0;
    bus_if.flush    = 1'b0;
    bus_if.bus_gnt  = 1'b1;
    bus_if.ft_txe_n = 1'b0;
    do_reset();

    check("reset_outputs", 32'(pack_out()), 32'({1'b0,1'b0,1'b1,1'b1,1'b1,8'h00,5'd0}));
    check("reset_busy", 32'(busy), 0);

    // Single-byte burst, cycle by cycle.
    e0 = 0;
    for (int i = 0; i < 7; i++) begin
      bus_if.tx_valid = vecs[i].valid;
      bus_if.tx_data  = vecs[i].data;
      bus_if.ft_txe_n = vecs[i].txe_n;
      bus_if.bus_gnt  = vecs[i].gnt;
      tick();
      if (i == 0) e0 = cyc;
      check($sformatf("single_row%0d", i), 32'(pack_out()), 32'(vecs[i].exp));
    end
    check("single_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("single_rx_byte", 32'(rx_q[0]), 32'hA5);
    // Pending is set once the idle counter has run SIWU_IDLE cycles; pulse follows.
    for (int i = 0; i < 400; i++) tick();
    check("single_siwu_count", siwu_lows, 1);
    check("single_siwu_delay", siwu_cyc - e0, SIWU_IDLE + 1);

    // Back pressure: fill all 16 entries, then drain with a 20-cycle stall.
    do_reset();
    bus_if.ft_txe_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i));
      check($sformatf("bp_count%0d", i), 32'(fifo_count), i + 1);
      check($sformatf("bp_ready%0d", i), 32'(bus_if.tx_ready), (i < 15) ? 1 : 0);
    end
    push_byte(8'hFF);
    check("bp_full_ignored", 32'(fifo_count), 16);
    bus_if.ft_txe_n = 1'b0;
    for (int i = 0; i < 50 && rx_q.size() < 5; i++) tick();
    check("bp_first_five", rx_q.size(), 5);
    bus_if.ft_txe_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("bp_stall_no_write", rx_q.size(), 5);
    check("bp_stall_released", 32'({bus_if.ft_doe, bus_if.bus_req, bus_if.ft_wr_n}), 32'b001);
    bus_if.ft_txe_n = 1'b0;
    for (int i = 0; i < 100 && !(rx_q.size() >= 16 && !busy); i++) tick();
    check("bp_rx_total", rx_q.size(), 16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++)
      check($sformatf("bp_rx%0d", i), 32'(rx_q[i]), i);
    check("bp_drained", 32'({busy, fifo_count}), 0);

    // Late grant: pads stay idle until the arbiter answers.
    do_reset();
    bus_if.bus_gnt  = 1'b0;
    bus_if.ft_txe_n = 1'b0;
    push_byte(8'h3C);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("lg_wait%0d", i),
            32'({bus_if.bus_req, bus_if.ft_doe, bus_if.ft_wr_n}), 32'b101);
    end
    bus_if.bus_gnt = 1'b1;
    tick();
    g = cyc;
    check("lg_turn", 32'({bus_if.ft_doe, bus_if.ft_wr_n}), 32'b11);
    for (int i = 0; i < 10 && rx_q.size() < 1; i++) tick();
    check("lg_rx", rx_q.size() > 0 ? 32'(rx_q[0]) : -1, 32'h3C);
    check("lg_write_delay", write_cyc - g, 2);

    // Flush while 5 bytes are queued: one pulse once drained and idle.
    do_reset();
    bus_if.bus_gnt  = 1'b1;
    bus_if.ft_txe_n = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    check("fl_queued", 32'(fifo_count), 5);
    check("fl_no_early_siwu", siwu_lows, 0);
    bus_if.ft_txe_n = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check("fl_rx_total", rx_q.size(), 5);
    check("fl_siwu_count", siwu_lows, 1);
    check("fl_siwu_after_release", siwu_cyc - doe_fall_cyc, 1);

    // Reset in the middle of a WRITE burst.
    do_reset();
    bus_if.ft_txe_n = 1'b1;
    for (int i = 0; i < 8; i++) push_byte(8'h40 + 8'(i));
    bus_if.ft_txe_n = 1'b0;
    for (int i = 0; i < 10 && bus_if.ft_wr_n; i++) tick();
    check("rs_in_write", 32'(bus_if.ft_wr_n), 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rs_outputs", 32'(pack_out()), 32'({1'b0,1'b0,1'b1,1'b1,1'b1,8'h00,5'd0}));
    check("rs_busy", 32'(busy), 0);
    rst = 1'b0;
    n_before  = rx_q.size();
    siwu_lows = 0;
    for (int i = 0; i < 300; i++) tick();
    check("rs_no_writes", rx_q.size(), n_before);
    check("rs_no_siwu", siwu_lows, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
